pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline-stage register, the successor to the fixed
//  per-stage bundle registers between pipeline stages (e.g. M->W).
//  - Carries an arbitrary packed control/data payload under a valid/ready handshake.
//  - A 2-entry skid buffer keeps full throughput while breaking the combinational
//    path from out_ready to in_ready.
//  - Adds synchronous flush and an occupancy output for hazard/flush control.
// PARAMETERS
//  WIDTH      32   payload bits (packed stage bundle, e.g. {PCSrc,RegWrite,MemtoReg,Rd,ALUResult,ReadData})
//  RESET_VAL  '0   payload value loaded on reset and on flush (WIDTH bits)
//  CNT_W      16   width of stall statistics counter
// PORTS
//  clk        in   1        clock, rising edge
//  reset      in   1        asynchronous, active-high
//  flush      in   1        synchronous flush, kills all held entries
//  in_valid   in   1        upstream payload valid
//  in_ready   out  1        stage can accept (registered)
//  in_data    in   WIDTH    upstream payload
//  out_valid  out  1        downstream payload valid
//  out_ready  in   1        downstream accepts
//  out_data   out  WIDTH    downstream payload (main entry)
//  occupancy  out  2        entries held: 0, 1 or 2
//  stall_cnt  out  CNT_W    cycles with out_valid & !out_ready (see CONFIGURATION)
// BEHAVIOUR
//  - Handshake signals:
//    - accept = in_valid & in_ready; take = out_valid & out_ready.
//    - Storage: main entry (drives out_data) and skid entry.
//  - States:
//    - EMPTY (occ 0): out_valid=0, in_ready=1.
//    - ONE (occ 1): out_valid=1, in_ready=1.
//    - FULL (occ 2): out_valid=1, in_ready=0.
//  - Reset (async): state EMPTY. Outputs out_valid=0, in_ready=1, occupancy=0,
//    out_data=RESET_VAL, skid=RESET_VAL, stall_cnt=0.
//  - Transitions (evaluated at posedge):
//    - EMPTY: accept -> ONE, main<=in_data; else stay EMPTY.
//    - ONE: accept & take -> ONE, main<=in_data.
//    - ONE: accept & !take -> FULL, skid<=in_data, main holds.
//    - ONE: !accept & take -> EMPTY.
//    - ONE: neither -> hold.
//    - FULL: take -> ONE, main<=skid. No accept is possible since in_ready=0.
//    - FULL: !take -> hold.
//  - Latency: 1 cycle from accept in EMPTY to out_valid. Throughput is 1 transfer
//    per cycle while out_ready=1.
//  - in_ready is a flop: in_ready = (next state != FULL). It never depends
//    combinationally on out_ready.
//  - Stability: while out_valid & !out_ready, out_data and out_valid hold.
//  - Ordering: strict FIFO order. No payload is dropped or duplicated except on flush.
//  - Flush:
//    - Has priority over every transition.
//    - Next state EMPTY; main and skid <= RESET_VAL.
//    - Any accept or take in the flush cycle is discarded.
//    - in_ready=1 the cycle after a flush.
//  - Reset mid-operation: immediate return to reset values, no clock needed.
//  - Width: payload passes through unmodified.
//  - occupancy equals the state encoding 0/1/2; the value 3 never occurs.
// CONFIGURATION
//  - Macro PIPE_STATS_EN defined:
//    - stall_cnt increments each cycle with out_valid & !out_ready.
//    - Saturates at all-ones and never wraps.
//    - Cleared only by reset; flush does not clear it.
//  - Macro PIPE_STATS_EN undefined: counter logic is absent and stall_cnt is tied to 0.
// TESTING
//  1. Reset released, in_valid=1, in_data=0x11, out_ready=1 -> next cycle
//     out_valid=1, out_data=0x11, occupancy=1.
//  2. Streaming: 0x01..0x08 sent on consecutive cycles, out_ready=1 ->
//     same order, one per cycle, in_ready stays 1.
//  3. Backpressure: out_ready=0, send 0xA, 0xB -> occupancy=2, in_ready=0,
//     out_data=0xA held. Then out_ready=1 -> 0xA, then 0xB.
//  4. Flush while FULL with in_valid=1, in_data=0xC -> next cycle occupancy=0,
//     out_valid=0, out_data=RESET_VAL, in_ready=1. 0xC is never output.
//  5. Reset asserted mid-stream, between clock edges -> out_valid=0,
//     in_ready=1, out_data=RESET_VAL immediately.
//  6. PIPE_STATS_EN, CNT_W=4, out_valid=1, out_ready=0 for 20 cycles ->
//     stall_cnt=15 (saturated). Flush leaves it at 15; reset returns it to 0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic
//   Elastic pipeline-stage register with a 2-entry skid buffer.
//   The payload moves under a valid/ready handshake.
//   in_ready is a flop, so out_ready never reaches it combinationally.
//   A synchronous flush kills every held entry.
//   The occupancy output reports how many entries are held.
//   Optional feature: define PIPE_STATS_EN to build the saturating stall counter.
//   With PIPE_STATS_EN undefined, stall_cnt is tied to zero.
module pipe_stage_elastic #(
    parameter int unsigned           WIDTH     = 32,
    parameter logic [WIDTH-1:0]      RESET_VAL = '0,
    parameter int unsigned           CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q,  main_d;
    logic [WIDTH-1:0] skid_q,  skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             accept_s;
    logic             take_s;

    assign accept_s = in_valid & in_ready_q;
    assign take_s   = out_valid_q & out_ready;

    // Next-state, storage and handshake-flag computation; flush overrides everything.
    always_comb begin
        state_d     = state_q;
        main_d      = main_q;
        skid_d      = skid_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && take_s) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end else if (accept_s) begin
                        // Downstream stalled: park the new beat in the skid entry.
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (take_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so no accept can occur.
                    if (take_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = RESET_VAL;
                    skid_d  = RESET_VAL;
                end
            endcase
        end
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // State, payload storage and registered handshake flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= RESET_VAL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign occupancy = state_q;

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a valid output is held back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = {CNT_W{1'b0}};
`endif

endmodule
